// File: rtl/matmul_sequencer.sv
// Sequences a shared 4-port 256x16 memory to compute C = A x B for N x N signed matrices.
// Define MATMUL_SATURATE_EN to clamp each C word to the signed 16-bit range instead of wrapping.
module matmul_sequencer #(
   parameter int N      = 4,
   parameter int A_BASE = 0,
   parameter int B_BASE = 64,
   parameter int C_BASE = 128
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [7:0]  rd_addr_a,
   input  logic [15:0] rd_data_a,
   output logic [7:0]  rd_addr_b,
   input  logic [15:0] rd_data_b,
   output logic        wr_en_c,
   output logic [7:0]  wr_addr_c,
   output logic [15:0] wr_data_c
);

   // state | meaning
   // IDLE  | waiting for start
   // RUN   | issue A/B addresses for k, accumulate product of k-1
   // DRAIN | accumulate product of k = N-1
   // WRITE | write C[i][j], advance j/i
   // DONE  | one-cycle completion pulse
   typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_WRITE, S_DONE} state_t;

   localparam logic [3:0] LAST   = 4'(N - 1);
   localparam logic [7:0] N8     = 8'(N);
   localparam logic [7:0] A_BASE8 = 8'(A_BASE);
   localparam logic [7:0] B_BASE8 = 8'(B_BASE);
   localparam logic [7:0] C_BASE8 = 8'(C_BASE);

   state_t             state_q, state_d;
   logic [3:0]         i_q, i_d, j_q, j_d, k_q, k_d;
   logic signed [31:0] acc_q, acc_d;
   logic [7:0]         rd_addr_a_q, rd_addr_a_d;
   logic [7:0]         rd_addr_b_q, rd_addr_b_d;
   logic [7:0]         wr_addr_c_q, wr_addr_c_d;

   logic [7:0]         addr_a_cur, addr_b_cur, addr_c_cur;
   logic signed [31:0] prod;

   function automatic logic [15:0] result_f(input logic signed [31:0] a);
`ifdef MATMUL_SATURATE_EN
      if (a > 32'sd32767) return 16'h7FFF;
      else if (a < -32'sd32768) return 16'h8000;
      else return a[15:0];
`else
      return a[15:0];
`endif
   endfunction

   assign addr_a_cur = A_BASE8 + {4'b0, i_q} * N8 + {4'b0, k_q};
   assign addr_b_cur = B_BASE8 + {4'b0, k_q} * N8 + {4'b0, j_q};
   assign addr_c_cur = C_BASE8 + {4'b0, i_q} * N8 + {4'b0, j_q};
   assign prod       = $signed(rd_data_a) * $signed(rd_data_b);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         i_q         <= '0;
         j_q         <= '0;
         k_q         <= '0;
         acc_q       <= '0;
         rd_addr_a_q <= '0;
         rd_addr_b_q <= '0;
         wr_addr_c_q <= '0;
      end else begin
         state_q     <= state_d;
         i_q         <= i_d;
         j_q         <= j_d;
         k_q         <= k_d;
         acc_q       <= acc_d;
         rd_addr_a_q <= rd_addr_a_d;
         rd_addr_b_q <= rd_addr_b_d;
         wr_addr_c_q <= wr_addr_c_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (k_q == LAST) state_d = S_DRAIN;
         S_DRAIN: state_d = S_WRITE;
         S_WRITE: state_d = (i_q == LAST && j_q == LAST) ? S_DONE : S_RUN;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      i_d         = i_q;
      j_d         = j_q;
      k_d         = k_q;
      acc_d       = acc_q;
      rd_addr_a_d = rd_addr_a_q;
      rd_addr_b_d = rd_addr_b_q;
      wr_addr_c_d = wr_addr_c_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               i_d   = '0;
               j_d   = '0;
               k_d   = '0;
               acc_d = '0;
            end
         end
         S_RUN: begin
            // read data lags the address by a cycle, so k = 0 has nothing to add yet
            if (k_q != 4'd0) acc_d = acc_q + prod;
            k_d         = k_q + 4'd1;
            rd_addr_a_d = addr_a_cur;
            rd_addr_b_d = addr_b_cur;
         end
         S_DRAIN: acc_d = acc_q + prod;
         S_WRITE: begin
            acc_d       = '0;
            k_d         = '0;
            wr_addr_c_d = addr_c_cur;
            if (j_q == LAST) begin
               j_d = '0;
               i_d = i_q + 4'd1;
            end else begin
               j_d = j_q + 4'd1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      busy      = (state_q == S_RUN) || (state_q == S_DRAIN) || (state_q == S_WRITE);
      done      = (state_q == S_DONE);
      wr_en_c   = (state_q == S_WRITE);
      rd_addr_a = (state_q == S_RUN)   ? addr_a_cur : rd_addr_a_q;
      rd_addr_b = (state_q == S_RUN)   ? addr_b_cur : rd_addr_b_q;
      wr_addr_c = (state_q == S_WRITE) ? addr_c_cur : wr_addr_c_q;
      wr_data_c = (state_q == S_WRITE) ? result_f(acc_q) : 16'h0000;
   end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: N=2 and N=1 instances on behavioural memories,
// directed and random jobs checked against an arithmetic matrix-product model.
module tb_matmul_sequencer;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset_n;
   logic        start2, busy2, done2, wr_en2;
   logic [7:0]  ra2, rb2, wa2;
   logic [15:0] da2, db2, wd2;
   logic        start1, busy1, done1, wr_en1;
   logic [7:0]  ra1, rb1, wa1;
   logic [15:0] da1, db1, wd1;

   logic        hwe, hsel;
   logic [7:0]  ha;
   logic [15:0] hd;
   logic [15:0] mem2 [256];
   logic [15:0] mem1 [256];

   logic [15:0] ma [4];
   logic [15:0] mb [4];

   int total = 0;
   int bad   = 0;

   matmul_sequencer #(.N(2), .A_BASE(0), .B_BASE(64), .C_BASE(128)) dut2 (
      .clock(clock), .reset_n(reset_n), .start(start2), .busy(busy2), .done(done2),
      .rd_addr_a(ra2), .rd_data_a(da2), .rd_addr_b(rb2), .rd_data_b(db2),
      .wr_en_c(wr_en2), .wr_addr_c(wa2), .wr_data_c(wd2));

   matmul_sequencer #(.N(1), .A_BASE(0), .B_BASE(64), .C_BASE(128)) dut1 (
      .clock(clock), .reset_n(reset_n), .start(start1), .busy(busy1), .done(done1),
      .rd_addr_a(ra1), .rd_data_a(da1), .rd_addr_b(rb1), .rd_data_b(db1),
      .wr_en_c(wr_en1), .wr_addr_c(wa1), .wr_data_c(wd1));

   // ports 0/1 read with one-cycle latency, port 2 write, port 3 host
   always @(posedge clock) begin
      da2 <= mem2[ra2];
      db2 <= mem2[rb2];
      da1 <= mem1[ra1];
      db1 <= mem1[rb1];
      if (wr_en2) mem2[wa2] <= wd2;
      if (wr_en1) mem1[wa1] <= wd1;
      if (hwe && !hsel) mem2[ha] <= hd;
      if (hwe && hsel)  mem1[ha] <= hd;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] ref_c(input int n, input int i, input int j);
      longint s = 0;
      logic signed [31:0] acc;
      for (int k = 0; k < n; k++)
         s += longint'($signed(ma[i*n+k])) * longint'($signed(mb[k*n+j]));
      acc = s[31:0];
`ifdef MATMUL_SATURATE_EN
      if (acc > 32767) return 16'h7FFF;
      if (acc < -32768) return 16'h8000;
`endif
      return acc[15:0];
   endfunction

   task automatic host_wr(input bit sel, input logic [7:0] a, input logic [15:0] d);
      @(negedge clock);
      hwe = 1'b1; hsel = sel; ha = a; hd = d;
      @(negedge clock);
      hwe = 1'b0;
   endtask

   task automatic load(input int n);
      for (int e = 0; e < n*n; e++) begin
         host_wr(n == 1, 8'(e),       ma[e]);
         host_wr(n == 1, 8'(64 + e),  mb[e]);
         host_wr(n == 1, 8'(128 + e), 16'hDEAD);
      end
   endtask

   // N=2 job; samples each negedge, cycle 1 being the first RUN cycle
   task automatic run2(input string tag, input bit hold, input int repulse);
      int cyc = 1, busy_n = 0, done_n = 0, done_at = 0, wr_n = 0;
      logic [7:0] wq [$];
      @(negedge clock); start2 = 1'b1;
      @(negedge clock);
      while (cyc <= 60) begin
         if (busy2) busy_n++;
         if (wr_en2) begin wr_n++; wq.push_back(wa2); end
         if (done2) begin done_n++; if (done_at == 0) done_at = cyc; end
         if (hold && done2) break;
         if (done_at != 0 && cyc >= done_at + 3) break;
         start2 = hold || (cyc == repulse);
         @(negedge clock); cyc++;
      end
      chk({tag, "_done_at"}, 32'(done_at), 32'd17);
      chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd16);
      chk({tag, "_done_pulses"}, 32'(done_n), 32'd1);
      chk({tag, "_wr_pulses"}, 32'(wr_n), 32'd4);
      if (wq.size() == 4)
         for (int e = 0; e < 4; e++) chk({tag, "_wr_addr"}, 32'(wq[e]), 32'(128 + e));
      for (int e = 0; e < 4; e++) chk({tag, "_c"}, 32'(mem2[128+e]), 32'(ref_c(2, e/2, e%2)));
   endtask

   task automatic run1(input string tag);
      int cyc = 1, busy_n = 0, done_at = 0, wr_n = 0;
      logic [7:0]  wa_seen = 8'h00;
      logic [15:0] wd_seen = 16'h0000;
      @(negedge clock); start1 = 1'b1;
      @(negedge clock); start1 = 1'b0;
      while (cyc <= 30) begin
         if (busy1) busy_n++;
         if (wr_en1) begin wr_n++; wa_seen = wa1; wd_seen = wd1; end
         if (done1 && done_at == 0) done_at = cyc;
         if (done_at != 0 && cyc >= done_at + 2) break;
         @(negedge clock); cyc++;
      end
      chk({tag, "_done_at"}, 32'(done_at), 32'd4);
      chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd3);
      chk({tag, "_wr_pulses"}, 32'(wr_n), 32'd1);
      chk({tag, "_wr_addr"}, 32'(wa_seen), 32'd128);
      chk({tag, "_wr_data"}, 32'(wd_seen), 32'(ref_c(1, 0, 0)));
      chk({tag, "_c"}, 32'(mem1[128]), 32'(ref_c(1, 0, 0)));
   endtask

   task automatic set_s1();
      ma = '{16'd1, 16'd2, 16'd3, 16'd4};
      mb = '{16'd5, 16'd6, 16'd7, 16'd8};
   endtask

   initial begin
      int wr_after, t;
      reset_n = 1'b0; start2 = 1'b0; start1 = 1'b0;
      hwe = 1'b0; hsel = 1'b0; ha = 8'h00; hd = 16'h0000;
      repeat (3) @(negedge clock);
      chk("rst_busy", 32'(busy2), 32'd0);
      chk("rst_done", 32'(done2), 32'd0);
      chk("rst_wr_en", 32'(wr_en2), 32'd0);
      chk("rst_addr_a", 32'(ra2), 32'd0);
      chk("rst_addr_b", 32'(rb2), 32'd0);
      chk("rst_addr_c", 32'(wa2), 32'd0);
      chk("rst_wdata", 32'(wd2), 32'd0);
      chk("rst_addr_c_n1", 32'(wa1), 32'd0);
      reset_n = 1'b1;

      // scenario 1
      set_s1(); load(2);
      run2("s1", 1'b0, 0);
      chk("s1_c00", 32'(mem2[128]), 32'd19);
      chk("s1_c01", 32'(mem2[129]), 32'd22);
      chk("s1_c10", 32'(mem2[130]), 32'd43);
      chk("s1_c11", 32'(mem2[131]), 32'd50);
      chk("s1_hold_addr_a", 32'(ra2), 32'd3);
      chk("s1_hold_addr_b", 32'(rb2), 32'd67);

      // scenario 2
      ma = '{16'hFFFF, 16'd2, 16'd0, 16'hFFFD};
      mb = '{16'd1, 16'd0, 16'd0, 16'd1};
      load(2);
      run2("s2", 1'b0, 0);
      chk("s2_c00", 32'(mem2[128]), 32'h0000FFFF);
      chk("s2_c11", 32'(mem2[131]), 32'h0000FFFD);

      // scenario 3
      ma = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
      mb = ma;
      load(2);
      run2("s3", 1'b0, 0);
`ifdef MATMUL_SATURATE_EN
      chk("s3_c00", 32'(mem2[128]), 32'h00007FFF);
`else
      chk("s3_c00", 32'(mem2[128]), 32'h00000002);
`endif

      // scenario 4: mid-job pulse, then start held through done
      set_s1(); load(2);
      run2("s4_pulse", 1'b0, 5);
      load(2);
      run2("s4_hold", 1'b1, 0);
      @(negedge clock);
      chk("s4_idle_busy", 32'(busy2), 32'd0);
      chk("s4_idle_done", 32'(done2), 32'd0);
      @(negedge clock);
      chk("s4_restart_busy", 32'(busy2), 32'd1);
      start2 = 1'b0;
      t = 0;
      while (!done2 && t < 60) begin @(negedge clock); t++; end
      chk("s4_restart_done", 32'(done2), 32'd1);
      load(2);
      run2("s4_repulse", 1'b0, 0);

      // scenario 5: reset during RUN of element (0,1)
      set_s1(); load(2);
      @(negedge clock); start2 = 1'b1;
      @(negedge clock); start2 = 1'b0;
      repeat (4) @(negedge clock);
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      chk("s5_busy", 32'(busy2), 32'd0);
      wr_after = 0;
      for (int c = 0; c < 20; c++) begin
         if (wr_en2 || done2) wr_after++;
         @(negedge clock);
      end
      chk("s5_no_writes", 32'(wr_after), 32'd0);
      chk("s5_c00", 32'(mem2[128]), 32'd19);
      for (int e = 1; e < 4; e++) chk("s5_c_kept", 32'(mem2[128+e]), 32'h0000DEAD);

      // scenario 6
      ma[0] = 16'h0003; mb[0] = 16'hFFFE;
      load(1);
      run1("s6");
      chk("s6_c", 32'(mem1[128]), 32'h0000FFFA);

      // random jobs
      for (int r = 0; r < 8; r++) begin
         for (int e = 0; e < 4; e++) begin
            if (r % 2 == 0) begin
               ma[e] = 16'($urandom);
               mb[e] = 16'($urandom);
            end else begin
               ma[e] = 16'($urandom_range(0, 15)) - 16'd8;
               mb[e] = 16'($urandom_range(0, 15)) - 16'd8;
            end
         end
         load(2);
         run2("rnd2", 1'b0, (r % 3 == 0) ? 9 : 0);
         load(1);
         run1("rnd1");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
Sequences the shared 4-port 256x16 data memory to compute C = A x B for N x N signed 16-bit matrices held in fixed memory regions.
- Port 0 reads A; connect write_en0 = 0 and addr0 = rd_addr_a.
- Port 1 reads B; connect write_en1 = 0 and addr1 = rd_addr_b.
- Port 2 writes C: wr_en_c, wr_addr_c and wr_data_c drive write_en2, addr2 and datain2. dataout2 is unused.
- Port 3 is left to the host for loading and unloading matrices while the sequencer is idle.

Parameters:
- N, 4, matrix dimension; legal range 1..8.
- A_BASE, 0, word address of A[0][0]; row-major.
- B_BASE, 64, word address of B[0][0]; row-major.
- C_BASE, 128, word address of C[0][0]; row-major.
- Constraint: the A, B and C regions (N*N words each) must not overlap.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  begin a multiply; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse after the last C write.
- rd_addr_a  out  8  to memory addr0.
- rd_data_a  in  16  from memory dataout0.
- rd_addr_b  out  8  to memory addr1.
- rd_data_b  in  16  from memory dataout1.
- wr_en_c  out  1  to memory write_en2.
- wr_addr_c  out  8  to memory addr2.
- wr_data_c  out  16  to memory datain2.

Behaviour:
Reset:
- On reset_n low at a clock edge: state = IDLE; busy, done, wr_en_c = 0; all addresses = 0; wr_data_c = 0.
- Accumulator and the i/j/k counters are cleared.
- Reset mid-operation abandons the job; no further C writes occur.

Memory timing:
- An address driven in cycle t is sampled at the end of t.
- rd_data is valid throughout cycle t+1, i.e. one-cycle read latency.

Addressing (all sums mod 256):
- rd_addr_a = A_BASE + i*N + k.
- rd_addr_b = B_BASE + k*N + j.
- wr_addr_c = C_BASE + i*N + j.

FSM states:
- IDLE
  - start = 1 → RUN, with i = j = k = 0, acc = 0, busy = 1.
  - start = 0 → stay in IDLE.
- RUN
  - Issue addresses for the current k each cycle, then k++.
  - From the second RUN cycle on, acc += rd_data_a * rd_data_b (product of the previous k).
  - After the address for k = N-1 is issued → DRAIN.
- DRAIN
  - One cycle; accumulates the product for k = N-1.
  - → WRITE.
- WRITE
  - wr_en_c = 1 for one cycle; wr_data_c = result(acc); acc cleared; k = 0.
  - Advance j, and when j wraps to 0 advance i.
  - Not the last element → RUN.
  - Last element (i = j = N-1) → DONE.
- DONE
  - done = 1 and busy = 0 for one cycle.
  - start is ignored in this state.
  - → IDLE.

Arithmetic and cycle counts:
- Operands are two's-complement signed 16-bit; each product is a signed 32-bit value.
- acc is a signed 32-bit accumulator that wraps mod 2^32.
- Default result(acc) = acc[15:0], i.e. wrap.
- Per element: N + 2 cycles. Job: N*N*(N+2) cycles from the first RUN cycle to the last WRITE, then one DONE cycle.
- N = 1 case: RUN (1 cycle) → DRAIN → WRITE → DONE.

Boundary conditions:
- start while busy or in DONE is ignored; the job is not restarted.
- wr_en_c is never asserted outside WRITE.
- rd_addr_a and rd_addr_b hold their last value outside RUN.

Optional Feature:
- Macro MATMUL_SATURATE_EN.
- Defined: result(acc) is acc clamped to [-32768, 32767]; 0x7FFF on positive overflow, 0x8000 on negative overflow.
- Not defined: result(acc) = acc[15:0] (wrap).
- Cycle timing is identical in both builds.

Test Plan:
1. N=2; A = [[1,2],[3,4]]; B = [[5,6],[7,8]]; pulse start → mem[128..131] = 19, 22, 43, 50. done pulses once, 16 cycles after the first RUN cycle. busy is high for exactly those 16 cycles.
2. N=2; A = [[-1,2],[0,-3]]; B = identity → C = [[0xFFFF,0x0002],[0x0000,0xFFFD]]. Also check wr_addr_c sequence 128, 129, 130, 131 and exactly four wr_en_c pulses.
3. N=2; all A and B elements = 0x7FFF → acc = 0x7FFE0002. C words = 0x0002 without MATMUL_SATURATE_EN; 0x7FFF with it.
4. Start held high throughout a job plus a second start pulse mid-job → no restart. A new job begins only after the cycle following done. A re-pulse from IDLE reproduces the C values of scenario 1.
5. reset_n low for one cycle during the RUN of element (0,1) → busy = 0 and no further wr_en_c. C[0][0] is already written; C[0][1..] keep their pre-job contents.
6. N=1; A = 0x0003; B = 0xFFFE → single write of 0xFFFA to address C_BASE. done pulses 3 cycles after the RUN cycle.
